// File: rtl/i2s_rx_slave_core.sv
// I2S receive slave: synchronises sck/ws/sd into wb_clk_i, deserialises MSB-first
// words with the standard one-bit ws delay and queues them in a small FIFO.
module i2s_rx_slave_core #(
  parameter int DATA_RES   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int INT_THRESH = 4
) (
  input  logic                               wb_clk_i,
  input  logic                               wb_rst_i,
  input  logic                               i2s_sck_i,
  input  logic                               i2s_ws_i,
  input  logic                               i2s_sd_i,
  input  logic                               enable_i,
  output logic [31:0]                        rx_dat_o,
  output logic                               rx_chan_o,
  output logic                               rx_valid_o,
  input  logic                               rx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    rx_level_o,
  output logic                               overrun_o,
  input  logic                               int_clr_i,
  output logic                               rx_int_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    SHIFT
  } state_t;

  state_t state_q, state_d;

  logic sck_s1, sck_s2, sck_s3;
  logic ws_s1, ws_s2;
  logic sd_s1, sd_s2;
  logic ws_prev;
  logic strobe;

  logic [DATA_RES-1:0] sh_q, sh_d, sh_bit;
  logic [5:0]          cnt_q, cnt_d;
  logic                push;
  logic [32:0]         push_word;

  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          full, pop, wr_en;

  // ---------------------------------------------------------------- synchronisers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sck_s1 <= 1'b0;
      sck_s2 <= 1'b0;
      sck_s3 <= 1'b0;
      ws_s1  <= 1'b0;
      ws_s2  <= 1'b0;
      sd_s1  <= 1'b0;
      sd_s2  <= 1'b0;
    end else begin
      sck_s1 <= i2s_sck_i;
      sck_s2 <= sck_s1;
      sck_s3 <= sck_s2;
      ws_s1  <= i2s_ws_i;
      ws_s2  <= ws_s1;
      sd_s1  <= i2s_sd_i;
      sd_s2  <= sd_s1;
    end
  end

  assign strobe = sck_s2 & ~sck_s3;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ws_prev <= 1'b0;
    end else if (strobe) begin
      ws_prev <= ws_s2;
    end
  end

  // ---------------------------------------------------------------- deserialiser FSM
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    sh_bit  = sh_q;
    // Slot position cnt maps to bit DATA_RES-1-cnt; bits past the resolution never match.
    for (int unsigned i = 0; i < DATA_RES; i++) begin
      if ({26'd0, cnt_q} == DATA_RES - 1 - i) begin
        sh_bit[i] = sd_s2;
      end
    end
    unique case (state_q)
      IDLE: begin
        sh_d  = '0;
        cnt_d = '0;
        if (enable_i) begin
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (strobe && (ws_s2 != ws_prev)) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (strobe) begin
          if (ws_s2 != ws_prev) begin
            // ws changes one bit early: this strobe's bit is the LSB slot of the ending word.
            push  = 1'b1;
            sh_d  = '0;
            cnt_d = '0;
          end else begin
            sh_d  = sh_bit;
            cnt_d = (cnt_q == 6'd63) ? cnt_q : cnt_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign push_word = {ws_prev, 32'(signed'(sh_bit))};

  // ---------------------------------------------------------------- FIFO
  assign full       = (level == LW'(FIFO_DEPTH));
  assign rx_valid_o = (level != '0);
  assign pop        = rx_valid_o & rx_ready_i;
  assign wr_en      = push & (~full | pop);

  always_ff @(posedge wb_clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_en && !pop) begin
        level <= level + 1'b1;
      end else if (!wr_en && pop) begin
        level <= level - 1'b1;
      end
    end
  end

  assign rx_dat_o   = rx_valid_o ? mem[rd_ptr][31:0] : '0;
  assign rx_chan_o  = rx_valid_o ? mem[rd_ptr][32] : 1'b0;
  assign rx_level_o = level;

  // ---------------------------------------------------------------- overrun / interrupt
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      overrun_o <= 1'b0;
    end else if (push && full && !pop) begin
      overrun_o <= 1'b1;
    end else if (int_clr_i) begin
      overrun_o <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_int_o <= 1'b0;
    end else begin
      rx_int_o <= (level >= LW'(INT_THRESH)) | overrun_o;
    end
  end

endmodule

// File: tb/tb_i2s_rx_slave_core.sv
// Bench for i2s_rx_slave_core: drives an I2S bus at wb_clk/8 and checks popped words
// against a word-level reference (first DATA_RES bits, zero padded, sign extended).
module tb_i2s_rx_slave_core;

  localparam int DR    = 16;
  localparam int DEPTH = 8;
  localparam int THR   = 4;

  logic        clk = 1'b0;
  logic        rst, sck, ws, sd, en, rdy, int_clr;
  logic [31:0] dat;
  logic        chan, valid, ovr, irq;
  logic [3:0]  level;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [32:0] exp_q[$];
  bit          exp_ovr;
  int          rmode;
  bit          pulse_ready;
  logic        nxt_ch;

  typedef struct {
    int unsigned len;
    logic [63:0] val;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  always #5 clk = ~clk;

  i2s_rx_slave_core #(
    .DATA_RES  (DR),
    .FIFO_DEPTH(DEPTH),
    .INT_THRESH(THR)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .i2s_sck_i (sck),
    .i2s_ws_i  (ws),
    .i2s_sd_i  (sd),
    .enable_i  (en),
    .rx_dat_o  (dat),
    .rx_chan_o (chan),
    .rx_valid_o(valid),
    .rx_ready_i(rdy),
    .rx_level_o(level),
    .overrun_o (ovr),
    .int_clr_i (int_clr),
    .rx_int_o  (irq)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Word-level reference: keep the first DR slot bits, pad short slots with zeros.
  function automatic logic [31:0] ref_exp(input int unsigned len, input logic [63:0] val);
    logic [63:0] v;
    logic [15:0] top;
    v = val & ((64'd1 << len) - 64'd1);
    if (len >= DR) v = v >> (len - DR);
    else           v = v << (DR - len);
    top = v[15:0];
    return {{16{top[15]}}, top};
  endfunction

  // Consumer side: every accepted head entry must be the oldest expected word.
  always @(negedge clk) begin
    if (!rst && valid && rdy) begin
      check("pop_has_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        check("pop_word", {31'd0, chan, dat}, {31'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic drive_ready();
    case (rmode)
      0: rdy = 1'b0;
      1: rdy = 1'b1;
      2: rdy = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_ready();
  endtask

  // One sck period (4 clk low, 4 clk high). sck rises just after a posedge; that
  // bit's push lands on the third following edge.
  task automatic send_bit(input logic b_ws, input logic b_sd, input bit last,
                          input logic [32:0] w, input bit measure);
    step();
    ws  = b_ws;
    sd  = b_sd;
    sck = 1'b0;
    repeat (3) step();
    step();
    sck = 1'b1;
    step();
    step();
    if (measure) check("valid_before_push", 64'(valid), 64'd0);
    if (pulse_ready && last) rdy = 1'b1;
    step();
    if (pulse_ready && last) rdy = 1'b0;
    if (last) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(w);
      else                      exp_ovr = 1'b1;
    end
    if (measure) check("valid_latency", 64'(valid), 64'd1);
  endtask

  task automatic send_word(input int unsigned len, input logic [63:0] val,
                           input logic [31:0] e, input bit push, input bit measure);
    logic b;
    logic wsb;
    for (int unsigned j = 0; j < len; j++) begin
      b   = val[len-1-j];
      wsb = (j == len - 1) ? ~nxt_ch : nxt_ch;
      send_bit(wsb, b, push && (j == len - 1), {nxt_ch, e}, measure && (j == len - 1));
    end
    nxt_ch = ~nxt_ch;
  endtask

  // Idle the bus on ws=1 while disabled, then a right-channel sync word whose
  // trailing ws edge aligns the receiver; the next word is left.
  task automatic sync_start();
    en = 1'b0;
    send_bit(1'b1, 1'b0, 1'b0, 33'd0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0, 33'd0, 1'b0);
    en     = 1'b1;
    nxt_ch = 1'b1;
    send_word(16, 64'($urandom), 32'd0, 1'b0, 1'b0);
  endtask

  task automatic settle(input int n);
    repeat (n) step();
  endtask

  initial begin
    logic [63:0] v;
    int unsigned len;

    tbl[0] = '{16, 64'hA5A5,     32'hFFFF_A5A5};
    tbl[1] = '{16, 64'h1234,     32'h0000_1234};
    tbl[2] = '{8,  64'hC3,       32'hFFFF_C300};
    tbl[3] = '{24, 64'h7ABCDE,   32'h0000_7ABC};
    tbl[4] = '{16, 64'h8000,     32'hFFFF_8000};
    tbl[5] = '{16, 64'h7FFF,     32'h0000_7FFF};
    tbl[6] = '{17, 64'h1FFFF,    32'hFFFF_FFFF};
    tbl[7] = '{1,  64'h1,        32'hFFFF_8000};
    tbl[8] = '{32, 64'hDEADBEEF, 32'hFFFF_DEAD};
    tbl[9] = '{15, 64'h7FFF,     32'hFFFF_FFFE};

    rst = 1'b1; sck = 1'b0; ws = 1'b0; sd = 1'b0; en = 1'b1; rdy = 1'b0; int_clr = 1'b0;
    rmode = 0; pulse_ready = 1'b0; exp_ovr = 1'b0; nxt_ch = 1'b0;

    // Reset while the bus toggles
    repeat (2) begin
      @(posedge clk);
      #1;
      sck = ~sck;
      ws  = ~ws;
      sd  = 1'($urandom_range(0, 1));
    end
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_dat",   64'(dat),   64'd0);
    check("rst_chan",  64'(chan),  64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovr",   64'(ovr),   64'd0);
    check("rst_int",   64'(irq),   64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sck = 1'b0;

    // Bits without any ws transition must not produce a word
    repeat (4) send_bit(1'b0, 1'b1, 1'b0, 33'd0, 1'b0);
    check("no_sync_valid", 64'(valid), 64'd0);

    // Stereo frame with latency check
    rmode = 1;
    sync_start();
    send_word(16, 64'hA5A5, 32'hFFFF_A5A5, 1'b1, 1'b1);
    send_word(16, 64'h1234, 32'h0000_1234, 1'b1, 1'b1);
    settle(4);
    check("stereo_drained", 64'(exp_q.size()), 64'd0);

    // Table of slot lengths / values
    for (int i = 0; i < 10; i++) begin
      send_word(tbl[i].len, tbl[i].val, tbl[i].exp, 1'b1, 1'b0);
    end
    settle(4);
    check("table_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: 9 words into an 8-deep FIFO
    rmode = 0;
    settle(2);
    for (int i = 0; i < 9; i++) begin
      v = 64'($urandom_range(0, 65535));
      send_word(16, v, ref_exp(16, v), 1'b1, 1'b0);
    end
    settle(2);
    check("bp_level",   64'(level), 64'(exp_q.size()));
    check("bp_overrun", 64'(ovr),   64'(exp_ovr));
    check("bp_int",     64'(irq),   64'((exp_q.size() >= THR) || exp_ovr));
    int_clr = 1'b1;
    step();
    int_clr = 1'b0;
    exp_ovr = 1'b0;
    check("ovr_cleared", 64'(ovr), 64'd0);
    rmode = 3;
    for (int i = 0; i < DEPTH; i++) begin
      rdy = 1'b1;
      step();
      rdy = 1'b0;
      check("drain_level", 64'(level), 64'(exp_q.size()));
      step();
      check("drain_int", 64'(irq), 64'(exp_q.size() >= THR));
    end

    // Full FIFO with a pop on the push edge
    rmode = 0;
    for (int i = 0; i < DEPTH; i++) begin
      v = 64'($urandom_range(0, 65535));
      send_word(16, v, ref_exp(16, v), 1'b1, 1'b0);
    end
    check("full_level", 64'(level), 64'(DEPTH));
    pulse_ready = 1'b1;
    send_word(16, 64'h0F0F, 32'h0000_0F0F, 1'b1, 1'b0);
    pulse_ready = 1'b0;
    settle(1);
    check("simul_level",   64'(level), 64'(exp_q.size()));
    check("simul_overrun", 64'(ovr),   64'(exp_ovr));
    rmode = 1;
    settle(12);
    check("simul_drained", 64'(exp_q.size()), 64'd0);

    // Disable after 5 bits, then re-sync
    for (int i = 0; i < 5; i++) begin
      send_bit(nxt_ch, 1'($urandom_range(0, 1)), 1'b0, 33'd0, 1'b0);
    end
    en = 1'b0;
    settle(3);
    sync_start();
    send_word(16, 64'h5A5A, 32'h0000_5A5A, 1'b1, 1'b0);
    send_word(16, 64'hC001, 32'hFFFF_C001, 1'b1, 1'b0);
    settle(4);
    check("disable_drained", 64'(exp_q.size()), 64'd0);

    // Randomised slots and consumer backpressure
    rmode = 2;
    for (int i = 0; i < 40; i++) begin
      len = $urandom_range(1, 40);
      v   = {$urandom, $urandom};
      send_word(len, v, ref_exp(len, v), 1'b1, 1'b0);
    end
    rmode = 1;
    settle(20);
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_overrun", 64'(ovr), 64'(exp_ovr));

    // Reset mid-word with entries queued
    rmode = 0;
    for (int i = 0; i < 3; i++) begin
      v = 64'($urandom_range(0, 65535));
      send_word(16, v, ref_exp(16, v), 1'b1, 1'b0);
    end
    for (int i = 0; i < 5; i++) begin
      send_bit(nxt_ch, 1'b1, 1'b0, 33'd0, 1'b0);
    end
    check("pre_rst_level", 64'(level), 64'(exp_q.size()));
    rst = 1'b1;
    sck = 1'b0;
    step();
    exp_q.delete();
    exp_ovr = 1'b0;
    check("midrst_valid", 64'(valid), 64'd0);
    check("midrst_level", 64'(level), 64'd0);
    check("midrst_ovr",   64'(ovr),   64'd0);
    step();
    rst   = 1'b0;
    rmode = 1;
    sync_start();
    send_word(16, 64'h2468, 32'h0000_2468, 1'b1, 1'b0);
    settle(4);
    check("post_rst_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

endmodule

// File: doc/i2s_rx_slave_core.md
# i2s_rx_slave_core

Receive-side I2S slave front end. It samples an externally driven I2S bus (serial clock, word select, serial data) in the `wb_clk_i` domain. It deserialises left and right channel words MSB-first with standard I2S one-bit delay, and buffers them in a small FIFO that the register/bus stage drains through a valid/ready handshake. It sits directly downstream of the I2S transmit master, which drives `i2s_sd`/`i2s_sck`/`i2s_ws`, and upstream of the receive data register and interrupt logic (`rxs_dat_i`, `rxs_int_o`).

## Interface
- DATA_RES, 16: sample resolution in bits, 8..32.
- FIFO_DEPTH, 8: FIFO entries, power of two, at least 2.
- INT_THRESH, 4: FIFO level at or above which the interrupt asserts, 1..FIFO_DEPTH.
- Clocking: one clock; reset is synchronous and active-high.
- wb_clk_i  in  1  system clock. Must be at least 4× the I2S serial clock.
- wb_rst_i  in  1  synchronous active-high reset.
- i2s_sck_i  in  1  I2S serial clock, asynchronous.
- i2s_ws_i  in  1  word select: 0 = left, 1 = right.
- i2s_sd_i  in  1  serial data.
- enable_i  in  1  receiver enable.
- rx_dat_o  out  32  sample, sign-extended from DATA_RES.
- rx_chan_o  out  1  channel of the head entry.
- rx_valid_o  out  1  FIFO not empty.
- rx_ready_i  in  1  consumer accepts the head entry.
- rx_level_o  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- overrun_o  out  1  sticky: a word was dropped on a full FIFO.
- int_clr_i  in  1  clears overrun_o.
- rx_int_o  out  1  registered interrupt.

## Operation
- **Synchronisers.** `sck`, `ws` and `sd` each pass through two flops (s1, s2). A third `sck` flop (s3) feeds edge detection. `strobe = sck_s2 & ~sck_s3`. All bit processing happens only in strobe cycles.
- **FSM states.** IDLE, SYNC, SHIFT.
  - IDLE: entered on reset or when `enable_i` = 0. The partial word and bit counter are cleared.
  - IDLE -> SYNC when `enable_i` = 1.
  - SYNC -> SHIFT on the first strobe where `ws_s2` differs from `ws_prev`. Nothing is pushed on this transition.
  - `ws_prev` updates on every strobe in every state.
- **SHIFT, per strobe:**
  - Bit capture: if `cnt` < DATA_RES, write `sh[DATA_RES-1-cnt]` = `sd_s2`. `cnt` increments and saturates at 63.
  - Word boundary: when `ws_s2` differs from `ws_prev`, the current bit is included first, because it is the LSB slot of the ending word. Then push {`ws_prev`, sign-extended `sh`}, clear `sh` and `cnt`, and continue.
  - The next strobe carries the MSB of the new channel.
- **Word length rules.**
  - A word longer than DATA_RES keeps only its first DATA_RES bits.
  - A word shorter than DATA_RES is zero-padded at the LSBs.
  - Sign extension always uses bit DATA_RES-1.
- **FIFO behaviour.**
  - Pop occurs when `rx_valid_o` and `rx_ready_i` are both high.
  - Push on a full FIFO without a same-cycle pop: the word is dropped and `overrun_o` is set.
  - Push and pop in the same cycle on a full FIFO: both are accepted and the level is unchanged.
  - Push and pop in the same cycle on an empty FIFO: only the push takes effect. There is no bypass path.
  - Pointers wrap modulo FIFO_DEPTH.
- **Overrun and interrupt.**
  - `overrun_o` is cleared by `int_clr_i`. If a set event and a clear occur in the same cycle, set wins.
  - `rx_int_o` is registered: (level ≥ INT_THRESH) | `overrun_o`.
- **Disable.** `enable_i` low discards the partial word. FIFO contents are retained and remain poppable.

## Timing
- **Reset values.** All outputs are 0. FIFO is empty, FSM is in IDLE, and sync flops, `ws_prev`, `sh` and `cnt` are 0.
- **Latency from pin to output.** A `sck` rising edge stable before `wb_clk_i` edge k is registered in s1 at k and s2 at k+1. The strobe is high in the cycle after k+1, and the push registers at edge k+2.
  - `rx_valid_o`, `rx_level_o` and `rx_dat_o` update after k+2.
  - `rx_int_o` updates one cycle later.
- **Pop.** Takes effect at the clock edge where valid & ready are high. The next head entry is presented in the following cycle.
- **Reset during operation.** Reset mid-word or mid-handshake empties the FIFO immediately. No partial word survives.

## Test plan
- **Reset.** Assert `wb_rst_i` for 2 cycles while the bus toggles. Required: every output is 0 and FSM is IDLE; after release, `rx_valid_o` stays 0 until a full word follows a `ws` transition.
- **Stereo frame.** DATA_RES=16, sck = `wb_clk_i`/8, 16-bit slots, L=0xA5A5, R=0x1234, `rx_ready_i`=1. Required: after the first sync word, pops yield {0, 0xFFFFA5A5} then {1, 0x00001234}; `rx_valid_o` is high within 3 cycles of the boundary sck edge.
- **Backpressure and overrun.** `rx_ready_i`=0, 9 words pushed, FIFO_DEPTH=8. Required: level = 8, `overrun_o`=1, `rx_int_o`=1; draining returns words 1–8 in order; `int_clr_i` clears `overrun_o`; `rx_int_o` drops once level < 4.
- **Slot width mismatch.** 8-bit slot 0xC3 -> 0xFFFFC300. 24-bit slot 0x7ABCDE -> 0x00007ABC.
- **Disable mid-word.** Drop `enable_i` after 5 bits, then re-enable. Required: no word is pushed for the interrupted slot; the first push carries data that starts after a fresh `ws` transition.
- **Full FIFO, simultaneous push and pop.** Required: level stays 8, `overrun_o` stays 0, and the new word appears last in drain order.
